// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with a data-memory request/ack
// controller that freezes the front of the pipe during slow accesses.
module ex_mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              EX_Valid_i,
  input  logic              EX_RegWrite_i,
  input  logic              EX_MemToReg_i,
  input  logic              EX_MemRead_i,
  input  logic              EX_MemWrite_i,
  input  logic [DATA_W-1:0] EX_ALUResult_i,
  input  logic [DATA_W-1:0] EX_WriteData_i,
  input  logic [REG_W-1:0]  EX_RegRD_i,
  output logic              MemReq_o,
  output logic              MemWe_o,
  output logic [DATA_W-1:0] MemAddr_o,
  output logic [DATA_W-1:0] MemWData_o,
  input  logic [DATA_W-1:0] MemRData_i,
  input  logic              MemAck_i,
  output logic              EM_RegWrite_o,
  output logic [REG_W-1:0]  EM_RegRD_o,
  output logic [DATA_W-1:0] EM_ALUResult_o,
  output logic              MW_RegWrite_o,
  output logic [REG_W-1:0]  MW_RegRD_o,
  output logic [DATA_W-1:0] MW_WBData_o,
  output logic              Stall_o,
  output logic [CNT_W-1:0]  StallCnt_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic              em_valid_q,     em_valid_d;
  logic              em_regwrite_q,  em_regwrite_d;
  logic              em_memtoreg_q,  em_memtoreg_d;
  logic              em_memread_q,   em_memread_d;
  logic              em_memwrite_q,  em_memwrite_d;
  logic [DATA_W-1:0] em_alu_q,       em_alu_d;
  logic [DATA_W-1:0] em_wdata_q,     em_wdata_d;
  logic [REG_W-1:0]  em_rd_q,        em_rd_d;

  logic              mw_regwrite_q,  mw_regwrite_d;
  logic [REG_W-1:0]  mw_rd_q,        mw_rd_d;
  logic [DATA_W-1:0] mw_wbdata_q,    mw_wbdata_d;

  logic [CNT_W-1:0]  stall_cnt_q,    stall_cnt_d;

  logic memop_c;
  logic stall_c;
  logic advance_c;

  // EM holds a real load/store; both MemRead and MemWrite set behaves as a store
  assign memop_c   = em_valid_q & (em_memread_q | em_memwrite_q);
  assign stall_c   = memop_c & ~MemAck_i;
  assign advance_c = ~stall_c;

  always_comb begin
    state_d       = state_q;
    em_valid_d    = em_valid_q;
    em_regwrite_d = em_regwrite_q;
    em_memtoreg_d = em_memtoreg_q;
    em_memread_d  = em_memread_q;
    em_memwrite_d = em_memwrite_q;
    em_alu_d      = em_alu_q;
    em_wdata_d    = em_wdata_q;
    em_rd_d       = em_rd_q;
    mw_regwrite_d = 1'b0;
    mw_rd_d       = '0;
    mw_wbdata_d   = '0;
    stall_cnt_d   = stall_cnt_q;

    case (state_q)
      ST_RUN:  if (stall_c)  state_d = ST_WAIT;
      ST_WAIT: if (MemAck_i) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    // Pipe advances unless a memory access is still outstanding
    if (advance_c) begin
      if (EX_Valid_i) begin
        em_valid_d    = 1'b1;
        em_regwrite_d = EX_RegWrite_i & (EX_RegRD_i != '0);
        em_memtoreg_d = EX_MemToReg_i;
        em_memread_d  = EX_MemRead_i;
        em_memwrite_d = EX_MemWrite_i;
        em_alu_d      = EX_ALUResult_i;
        em_wdata_d    = EX_WriteData_i;
        em_rd_d       = EX_RegRD_i;
      end else begin
        em_valid_d    = 1'b0;
        em_regwrite_d = 1'b0;
        em_memtoreg_d = 1'b0;
        em_memread_d  = 1'b0;
        em_memwrite_d = 1'b0;
        em_alu_d      = '0;
        em_wdata_d    = '0;
        em_rd_d       = '0;
      end
      mw_regwrite_d = em_regwrite_q;
      mw_rd_d       = em_rd_q;
      mw_wbdata_d   = em_memtoreg_q ? MemRData_i : em_alu_q;
    end

    if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_RUN;
      em_valid_q    <= 1'b0;
      em_regwrite_q <= 1'b0;
      em_memtoreg_q <= 1'b0;
      em_memread_q  <= 1'b0;
      em_memwrite_q <= 1'b0;
      em_alu_q      <= '0;
      em_wdata_q    <= '0;
      em_rd_q       <= '0;
      mw_regwrite_q <= 1'b0;
      mw_rd_q       <= '0;
      mw_wbdata_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      em_valid_q    <= em_valid_d;
      em_regwrite_q <= em_regwrite_d;
      em_memtoreg_q <= em_memtoreg_d;
      em_memread_q  <= em_memread_d;
      em_memwrite_q <= em_memwrite_d;
      em_alu_q      <= em_alu_d;
      em_wdata_q    <= em_wdata_d;
      em_rd_q       <= em_rd_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_rd_q       <= mw_rd_d;
      mw_wbdata_q   <= mw_wbdata_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Memory bus comes straight off the EM flops, so it is stable until ack
  assign MemReq_o       = memop_c & ((state_q == ST_RUN) || (state_q == ST_WAIT));
  assign MemWe_o        = em_memwrite_q;
  assign MemAddr_o      = em_alu_q;
  assign MemWData_o     = em_wdata_q;
  assign EM_RegWrite_o  = em_regwrite_q;
  assign EM_RegRD_o     = em_rd_q;
  assign EM_ALUResult_o = em_alu_q;
  assign MW_RegWrite_o  = mw_regwrite_q;
  assign MW_RegRD_o     = mw_rd_q;
  assign MW_WBData_o    = mw_wbdata_q;
  assign Stall_o        = stall_c;
  assign StallCnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed self-checking bench for ex_mem_wb_pipe; counter built narrow so
// saturation is reachable in a short run.
module tb_ex_mem_wb_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
  logic [DATA_W-1:0] ex_alu, ex_wdata;
  logic [REG_W-1:0]  ex_rd;
  logic              mem_req, mem_we, mem_ack;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              em_regwrite, mw_regwrite, stall;
  logic [REG_W-1:0]  em_rd, mw_rd;
  logic [DATA_W-1:0] em_alu, mw_wbdata;
  logic [CNT_W-1:0]  stall_cnt;

  int checks;
  int failures;

  ex_mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .EX_Valid_i     (ex_valid),
    .EX_RegWrite_i  (ex_regwrite),
    .EX_MemToReg_i  (ex_memtoreg),
    .EX_MemRead_i   (ex_memread),
    .EX_MemWrite_i  (ex_memwrite),
    .EX_ALUResult_i (ex_alu),
    .EX_WriteData_i (ex_wdata),
    .EX_RegRD_i     (ex_rd),
    .MemReq_o       (mem_req),
    .MemWe_o        (mem_we),
    .MemAddr_o      (mem_addr),
    .MemWData_o     (mem_wdata),
    .MemRData_i     (mem_rdata),
    .MemAck_i       (mem_ack),
    .EM_RegWrite_o  (em_regwrite),
    .EM_RegRD_o     (em_rd),
    .EM_ALUResult_o (em_alu),
    .MW_RegWrite_o  (mw_regwrite),
    .MW_RegRD_o     (mw_rd),
    .MW_WBData_o    (mw_wbdata),
    .Stall_o        (stall),
    .StallCnt_o     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic mr,
                        input logic mw, input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] wd, input logic [REG_W-1:0] rd);
    ex_valid = v; ex_regwrite = rw; ex_memtoreg = m2r; ex_memread = mr;
    ex_memwrite = mw; ex_alu = alu; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic bubble();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    bubble();
    #2;
    chk("rst_memreq", 64'(mem_req), 64'd0);
    chk("rst_em_rw", 64'(em_regwrite), 64'd0);
    chk("rst_mw_rw", 64'(mw_regwrite), 64'd0);
    chk("rst_mw_data", 64'(mw_wbdata), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    #5 rst_n = 1'b1;

    // add r3 <- 0x10
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3);
    #1 chk("add_stall", 64'(stall), 64'd0);
    tick(); bubble(); #1;
    chk("add_em_rw", 64'(em_regwrite), 64'd1);
    chk("add_em_rd", 64'(em_rd), 64'd3);
    chk("add_em_alu", 64'(em_alu), 64'h10);
    chk("add_stall2", 64'(stall), 64'd0);
    tick(); #1;
    chk("add_mw_rw", 64'(mw_regwrite), 64'd1);
    chk("add_mw_rd", 64'(mw_rd), 64'd3);
    chk("add_mw_data", 64'(mw_wbdata), 64'h10);

    // lw r5, 0x40 with zero-wait ack
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5);
    tick(); bubble(); mem_ack = 1'b1; mem_rdata = 32'hDEAD; #1;
    chk("lw0_req", 64'(mem_req), 64'd1);
    chk("lw0_we", 64'(mem_we), 64'd0);
    chk("lw0_addr", 64'(mem_addr), 64'h40);
    chk("lw0_stall", 64'(stall), 64'd0);
    tick(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("lw0_mw_data", 64'(mw_wbdata), 64'hDEAD);
    chk("lw0_mw_rd", 64'(mw_rd), 64'd5);
    chk("lw0_mw_rw", 64'(mw_regwrite), 64'd1);
    chk("lw0_req_drop", 64'(mem_req), 64'd0);
    chk("lw0_cnt", 64'(stall_cnt), 64'd0);

    // sw 0x1234 -> 0x80, ack on the fourth request cycle
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h1234, 5'd0);
    tick(); bubble();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      #1;
      chk($sformatf("sw_req%0d", i), 64'(mem_req), 64'd1);
      chk($sformatf("sw_we%0d", i), 64'(mem_we), 64'd1);
      chk($sformatf("sw_addr%0d", i), 64'(mem_addr), 64'h80);
      chk($sformatf("sw_wdata%0d", i), 64'(mem_wdata), 64'h1234);
      chk($sformatf("sw_stall%0d", i), 64'(stall), (i == 3) ? 64'd0 : 64'd1);
      chk($sformatf("sw_mw_rw%0d", i), 64'(mw_regwrite), 64'd0);
      tick();
    end
    mem_ack = 1'b0; #1;
    chk("sw_cnt", 64'(stall_cnt), 64'd3);
    chk("sw_req_drop", 64'(mem_req), 64'd0);
    chk("sw_mw_rw", 64'(mw_regwrite), 64'd0);

    // write to r0 is squashed
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd0);
    tick(); bubble(); #1;
    chk("r0_em_rw", 64'(em_regwrite), 64'd0);
    tick(); #1;
    chk("r0_mw_rw", 64'(mw_regwrite), 64'd0);

    // back-to-back loads: r6 <- [0x100] (1 wait), r7 <- [0x104] (zero wait)
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd6);
    tick();
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 5'd7);
    #1;
    chk("b2b_stall", 64'(stall), 64'd1);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hA1; #1;
    chk("b2b_addr1", 64'(mem_addr), 64'h100);
    chk("b2b_em_rd1", 64'(em_rd), 64'd6);
    tick(); bubble(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("b2b_req2", 64'(mem_req), 64'd1);
    chk("b2b_addr2", 64'(mem_addr), 64'h104);
    chk("b2b_mw_data1", 64'(mw_wbdata), 64'hA1);
    chk("b2b_mw_rd1", 64'(mw_rd), 64'd6);
    mem_ack = 1'b1; mem_rdata = 32'hB2; #1;
    chk("b2b_stall2", 64'(stall), 64'd0);
    tick(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("b2b_mw_data2", 64'(mw_wbdata), 64'hB2);
    chk("b2b_mw_rd2", 64'(mw_rd), 64'd7);
    chk("b2b_cnt", 64'(stall_cnt), 64'd4);

    // async reset abandons a load waiting in MEM_WAIT
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd8);
    tick(); bubble(); tick(); #1;
    chk("rw_req_wait", 64'(mem_req), 64'd1);
    chk("rw_cnt_pre", 64'(stall_cnt), 64'd5);
    rst_n = 1'b0; #1;
    chk("rw_req", 64'(mem_req), 64'd0);
    chk("rw_em_rw", 64'(em_regwrite), 64'd0);
    chk("rw_em_rd", 64'(em_rd), 64'd0);
    chk("rw_mw_rd", 64'(mw_rd), 64'd0);
    chk("rw_cnt", 64'(stall_cnt), 64'd0);
    chk("rw_stall", 64'(stall), 64'd0);
    #1 rst_n = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd9);
    tick(); bubble(); #1;
    chk("post_rst_stall", 64'(stall), 64'd0);
    tick(); #1;
    chk("post_rst_mw_data", 64'(mw_wbdata), 64'h77);
    chk("post_rst_mw_rd", 64'(mw_rd), 64'd9);

    // long stall saturates the counter at all-ones
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd10);
    tick(); bubble();
    for (int i = 0; i < 15; i++) tick();
    #1 chk("sat_cnt15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 5; i++) tick();
    #1 chk("sat_hold", 64'(stall_cnt), 64'd15);
    chk("sat_req", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'hC3;
    tick(); mem_ack = 1'b0; #1;
    chk("sat_after", 64'(stall_cnt), 64'd15);
    chk("sat_mw_data", 64'(mw_wbdata), 64'hC3);
    chk("sat_mw_rd", 64'(mw_rd), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core, with a data-memory request/acknowledge controller between them.
- Produces the EM_* and MW_* destination/write-enable signals the forwarding unit consumes.
- Produces the write-back bus to the register file.
- Stalls the front of the pipe while a variable-latency data-memory access is outstanding.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, memory data)
REG_W, 5, register specifier width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-low
EX_Valid_i  in  1  EX stage holds a real instruction (0 = bubble)
EX_RegWrite_i  in  1  instruction writes a register
EX_MemToReg_i  in  1  write-back source is memory (load)
EX_MemRead_i  in  1  load
EX_MemWrite_i  in  1  store
EX_ALUResult_i  in  DATA_W  ALU result / memory address
EX_WriteData_i  in  DATA_W  store data (already forwarded)
EX_RegRD_i  in  REG_W  destination register
MemReq_o  out  1  data-memory request
MemWe_o  out  1  1 = write, 0 = read
MemAddr_o  out  DATA_W  memory address
MemWData_o  out  DATA_W  store data
MemRData_i  in  DATA_W  load data, valid when MemAck_i=1
MemAck_i  in  1  access complete this cycle
EM_RegWrite_o  out  1  EX/MEM write enable (to forwarding)
EM_RegRD_o  out  REG_W  EX/MEM destination (to forwarding)
EM_ALUResult_o  out  DATA_W  EX/MEM forwarding data
MW_RegWrite_o  out  1  MEM/WB write enable (to forwarding and register file)
MW_RegRD_o  out  REG_W  MEM/WB destination
MW_WBData_o  out  DATA_W  write-back data
Stall_o  out  1  freeze PC, IF/ID, ID/EX this cycle
StallCnt_o  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
Reset (rst_i=0, asynchronous):
- All EM_*/MW_* outputs = 0, MemReq_o = 0, StallCnt_o = 0, state = RUN.
- Reset asserted during MEM_WAIT abandons the access: MemReq_o drops without waiting for the clock.

Capture into EM:
- EM_RegWrite is captured as EX_RegWrite_i & EX_Valid_i & (EX_RegRD_i != 0).
- r0 writes are never propagated.
- A bubble (EX_Valid_i=0) clears all EM control bits.

Memory-op detection:
- memop = EM valid & (MemRead | MemWrite).
- MemRead and MemWrite both set is illegal; treat as a store.

State machine (RUN, MEM_WAIT):
- MemReq_o = memop & state ∈ {RUN, MEM_WAIT}.
- MemAddr_o = EM_ALUResult. MemWData_o = EM write data. MemWe_o = EM MemWrite.
- Address, data and We are held stable from first assertion until ack.
- RUN, no memop: EM <- EX, MW <- EM. No stall.
- RUN, memop, MemAck_i=1: zero-wait access. EM <- EX and MW <- EM; load data is taken from MemRData_i this cycle. Stay in RUN.
- RUN, memop, MemAck_i=0: go to MEM_WAIT. EM holds. MW loads a bubble (MW_RegWrite=0).
- MEM_WAIT, MemAck_i=0: EM holds, MW loads a bubble, remain.
- MEM_WAIT, MemAck_i=1: EM <- EX, MW <- EM (load data captured), return to RUN.
- MemAck_i with no MemReq_o is ignored.

Stall_o:
- Combinational: Stall_o = memop & ~MemAck_i.
- Upstream holds EX inputs stable while Stall_o=1.

Write-back:
- MW_WBData_o = MemToReg ? captured MemRData_i : EM_ALUResult, registered.
- MW_RegRD_o = EM_RegRD, registered.

Latency:
- EX->EM: 1 cycle. EM->MW: 1 cycle plus wait cycles.
- A non-memory instruction reaches MW 2 edges after EX.

StallCnt_o:
- Increments on every rising edge where Stall_o=1.
- Saturates at all-ones with no wrap.

Back-to-back loads:
- The second load's request asserts in the cycle after the first load's ack.
- No idle cycle is inserted.

Test Plan:
- Reset then add r3 (RegWrite=1, RD=3, ALU=0x10) with no memop -> EM_RegWrite_o=1, EM_RegRD_o=3 after edge 1; MW_RegRD_o=3, MW_WBData_o=0x10 after edge 2; Stall_o never 1.
- lw r5, addr 0x40, MemAck_i high same cycle (zero-wait), MemRData_i=0xDEAD -> MemReq_o=1 for 1 cycle, Stall_o=0, MW_WBData_o=0xDEAD, MW_RegRD_o=5 next edge.
- sw to 0x80, data 0x1234, ack after 3 cycles -> MemReq_o/MemWe_o=1 with MemAddr_o=0x80 and MemWData_o=0x1234 stable 4 cycles; Stall_o=1 for 3 cycles; MW_RegWrite_o=0 during wait; StallCnt_o=3.
- Instruction with RD=0 and RegWrite=1 -> EM_RegWrite_o=0, MW_RegWrite_o=0.
- Load waiting in MEM_WAIT, then rst_i pulsed low mid-cycle -> MemReq_o, EM/MW outputs, StallCnt_o = 0 immediately, before the next clock edge; after release, state is RUN.
- Preload StallCnt to all-ones via a long stall (or a reduced CNT_W=2 build), then stall again -> StallCnt_o stays 3 (CNT_W=2), no wrap.
